// File: rtl/fxp_pkg.sv
// Shared fixed-point defaults, RMS-norm FSM states and the saturate/multiply
// helpers. Helpers work on 64-bit intermediates, so words up to 32 bits wide.
package fxp_pkg;

    localparam int FXP_N_DEF     = 16;
    localparam int FXP_Q_DEF     = 8;
    localparam int FXP_ARR_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SQRT,
        ST_RECIP,
        ST_SCALE,
        ST_DONE
    } rms_state_e;

    // (a*b) >>> q, arithmetic shift so rounding is toward -inf
    function automatic logic signed [63:0] fxp_mul_shr(input logic signed [31:0] a,
                                                       input logic signed [31:0] b,
                                                       input int q);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p >>> q;
    endfunction

    function automatic logic signed [63:0] fxp_sat(input logic signed [63:0] v,
                                                   input int n);
        logic signed [63:0] hi, lo, r;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        r  = v;
        if (v > hi) r = hi;
        if (v < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/fxp_isqrt.sv
// Digit-by-digit integer square root: one root bit per enabled cycle, N cycles
// after the load cycle. done and root are combinational on the final step.
module fxp_isqrt #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           start,
    input  logic [2*N-1:0] rad,
    output logic           done,
    output logic [N-1:0]   root
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = N + 2;
    localparam int SW = N + 4;

    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] rad_q, rad_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [N-1:0]   root_q, root_d;
    logic [SW-1:0]  rem_sh, trial;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rad_d  = rad_q;
        rem_d  = rem_q;
        root_d = root_q;
        done   = 1'b0;
        rem_sh = {rem_q, rad_q[2*N-1 -: 2]};
        trial  = SW'({root_q, 2'b01});
        if (en) begin
            if (start) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                rad_d  = rad;
                rem_d  = '0;
                root_d = '0;
            end else if (busy_q) begin
                if (rem_sh >= trial) begin
                    rem_d  = RW'(rem_sh - trial);
                    root_d = {root_q[N-2:0], 1'b1};
                end else begin
                    rem_d  = RW'(rem_sh);
                    root_d = {root_q[N-2:0], 1'b0};
                end
                rad_d = rad_q << 2;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    busy_d = 1'b0;
                    done   = 1'b1;
                end
            end
        end
        root = root_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
        end
    end

endmodule

// File: rtl/rms_norm_par.sv
// Multi-lane RMS normalisation: sum of squares, isqrt, restoring reciprocal,
// then per-element scale with optional gamma. Results hold until the next SCALE.
module rms_norm_par
    import fxp_pkg::*;
#(
    parameter int          ARR_WIDTH = FXP_ARR_W_DEF,
    parameter int          FXP_N     = FXP_N_DEF,
    parameter int          FXP_Q     = FXP_Q_DEF,
    parameter int          LANES     = 2,
    parameter int unsigned EPS       = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic                                 start,
    input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] input_arr,
    input  logic signed [ARR_WIDTH-1:0][FXP_N-1:0] gamma_arr,
    input  logic                                 gamma_en,
    output logic signed [ARR_WIDTH-1:0][FXP_N-1:0] output_arr,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 dbz
);
    localparam int LG    = $clog2(ARR_WIDTH);
    localparam int BEATS = ARR_WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ACW   = 2 * FXP_N + LG;
    localparam int MSW   = ACW + 1;
    localparam int QW    = 2 * FXP_Q + 1;
    localparam int RCW   = $clog2(QW);
    localparam logic [FXP_N-1:0] RECIP_MAX = {1'b0, {(FXP_N-1){1'b1}}};

    rms_state_e                     state_q, state_d;
    logic [ARR_WIDTH-1:0][FXP_N-1:0] x_q, x_d, g_q, g_d, y_q, y_d;
    logic                           gen_q, gen_d;
    logic [CW-1:0]                  bcnt_q, bcnt_d;
    logic [ACW-1:0]                 acc_q, acc_d;
    logic                           sq_start_q, sq_start_d;
    logic [FXP_N-1:0]               rms_q, rms_d, rem_q, rem_d, recip_q, recip_d;
    logic [QW-1:0]                  quo_q, quo_d, quo_nxt;
    logic [RCW-1:0]                 rcnt_q, rcnt_d;
    logic                           dbzp_q, dbzp_d, dbz_q, dbz_d;

    logic [MSW-1:0]                 ms_full;
    logic [2*FXP_N-1:0]             ms;
    logic                           sq_done;
    logic [FXP_N-1:0]               sq_root;
    logic [FXP_N:0]                 rem_sh;
    logic                           qbit;
    logic [LG-1:0]                  idx;
    logic signed [FXP_N-1:0]        xv, yv;
    logic signed [2*FXP_N-1:0]      sq;

    // Mean square saturates to the isqrt radicand width
    assign ms_full = MSW'(acc_q >> LG) + MSW'(EPS);
    assign ms      = (|ms_full[MSW-1:2*FXP_N]) ? '1 : ms_full[2*FXP_N-1:0];

    fxp_isqrt #(.N(FXP_N)) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .start (sq_start_q),
        .rad   (ms),
        .done  (sq_done),
        .root  (sq_root)
    );

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        g_d        = g_q;
        y_d        = y_q;
        gen_d      = gen_q;
        bcnt_d     = bcnt_q;
        acc_d      = acc_q;
        sq_start_d = sq_start_q;
        rms_d      = rms_q;
        rem_d      = rem_q;
        recip_d    = recip_q;
        quo_d      = quo_q;
        rcnt_d     = rcnt_q;
        dbzp_d     = dbzp_q;
        dbz_d      = dbz_q;
        idx        = '0;
        xv         = '0;
        yv         = '0;
        sq         = '0;
        // Dividend is 2^(2Q): its only set bit enters on the first divide step
        rem_sh     = {rem_q, (rcnt_q == '0)};
        qbit       = (rem_sh >= {1'b0, rms_q});
        quo_nxt    = {quo_q[QW-2:0], qbit};

        if (enable) begin
            sq_start_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_d     = input_arr;
                        g_d     = gamma_arr;
                        gen_d   = gamma_en;
                        acc_d   = '0;
                        bcnt_d  = '0;
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    for (int l = 0; l < LANES; l++) begin
                        idx   = LG'(int'(bcnt_q) * LANES + l);
                        xv    = $signed(x_q[idx]);
                        sq    = xv * xv;
                        acc_d = acc_d + {{LG{1'b0}}, sq};
                    end
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == CW'(BEATS - 1)) begin
                        bcnt_d     = '0;
                        sq_start_d = 1'b1;
                        state_d    = ST_SQRT;
                    end
                end
                ST_SQRT: begin
                    if (sq_done) begin
                        rms_d   = sq_root;
                        rem_d   = '0;
                        quo_d   = '0;
                        rcnt_d  = '0;
                        state_d = ST_RECIP;
                    end
                end
                ST_RECIP: begin
                    rem_d  = qbit ? FXP_N'(rem_sh - {1'b0, rms_q}) : FXP_N'(rem_sh);
                    quo_d  = quo_nxt;
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == RCW'(QW - 1)) begin
                        dbzp_d = (rms_q == '0);
                        if ((rms_q == '0) || (64'(quo_nxt) > 64'(RECIP_MAX)))
                            recip_d = RECIP_MAX;
                        else
                            recip_d = FXP_N'(quo_nxt);
                        bcnt_d  = '0;
                        state_d = ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    for (int l = 0; l < LANES; l++) begin
                        idx = LG'(int'(bcnt_q) * LANES + l);
                        xv  = $signed(x_q[idx]);
                        yv  = FXP_N'(fxp_sat(fxp_mul_shr(32'(xv), 32'(recip_q), FXP_Q), FXP_N));
                        if (gen_q)
                            yv = FXP_N'(fxp_sat(fxp_mul_shr(32'(yv), 32'($signed(g_q[idx])),
                                                            FXP_Q), FXP_N));
                        y_d[idx] = yv;
                    end
                    dbz_d  = dbzp_q;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == CW'(BEATS - 1)) begin
                        bcnt_d  = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            g_q        <= '0;
            y_q        <= '0;
            gen_q      <= 1'b0;
            bcnt_q     <= '0;
            acc_q      <= '0;
            sq_start_q <= 1'b0;
            rms_q      <= '0;
            rem_q      <= '0;
            recip_q    <= '0;
            quo_q      <= '0;
            rcnt_q     <= '0;
            dbzp_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            g_q        <= g_d;
            y_q        <= y_d;
            gen_q      <= gen_d;
            bcnt_q     <= bcnt_d;
            acc_q      <= acc_d;
            sq_start_q <= sq_start_d;
            rms_q      <= rms_d;
            rem_q      <= rem_d;
            recip_q    <= recip_d;
            quo_q      <= quo_d;
            rcnt_q     <= rcnt_d;
            dbzp_q     <= dbzp_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign dbz        = dbz_q;
    assign output_arr = y_q;

endmodule

// File: tb/tb_rms_norm_par.sv
// Directed bench for rms_norm_par at 8 elements, Q8.8, 2 lanes, EPS=0.
module tb_rms_norm_par;
    localparam int AW = 8;
    localparam int N  = 16;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b1;
    logic start = 1'b0;
    logic gamma_en = 1'b0;
    logic signed [AW-1:0][N-1:0] input_arr = '0;
    logic signed [AW-1:0][N-1:0] gamma_arr = '0;
    logic signed [AW-1:0][N-1:0] output_arr;
    logic busy, done, dbz;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0][N-1:0] vx, vg, vy;

    always #5 clk = ~clk;

    rms_norm_par #(.ARR_WIDTH(AW), .FXP_N(N), .FXP_Q(8), .LANES(L), .EPS(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start      (start),
        .input_arr  (input_arr),
        .gamma_arr  (gamma_arr),
        .gamma_en   (gamma_en),
        .output_arr (output_arr),
        .busy       (busy),
        .done       (done),
        .dbz        (dbz)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_y(input string tag, input logic [AW-1:0][N-1:0] e);
        for (int i = 0; i < AW; i++)
            chk($sformatf("%s_y%0d", tag, i), 32'(output_arr[i]), 32'(e[i]));
    endtask

    function automatic logic [AW-1:0][N-1:0] fill(input logic [N-1:0] v);
        logic [AW-1:0][N-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; the following edge accepts the start
    task automatic start_op(input logic [AW-1:0][N-1:0] x, input logic [AW-1:0][N-1:0] g,
                            input logic ge);
        input_arr = x;
        gamma_arr = g;
        gamma_en  = ge;
        start     = 1'b1;
        step();
        start     = 1'b0;
        // scramble captured inputs; the operation must not see these
        input_arr = ~x;
        gamma_arr = ~g;
        gamma_en  = ~ge;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
    endtask

    task automatic run(input string tag, input logic [AW-1:0][N-1:0] x,
                       input logic [AW-1:0][N-1:0] g, input logic ge,
                       input logic [AW-1:0][N-1:0] ey, input logic edbz);
        int c;
        start_op(x, g, ge);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(c);
        chk({tag, "_lat"}, 32'(c), 32'd42);
        chk_y(tag, ey);
        chk({tag, "_dbz"}, 32'(dbz), 32'(edbz));
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk_y({tag, "_hold"}, ey);
    endtask

    initial begin
        int c1, c2, seen;

        // reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        chk_y("rst", fill(16'h0000));
        rst_n = 1'b1;

        // unit vector, accepted on first edge after reset release
        run("ones", fill(16'h0100), fill(16'h0000), 1'b0, fill(16'h0100), 1'b0);

        // +/-2.0 alternating: rms 2.0, recip 0.5
        for (int i = 0; i < AW; i++) begin
            vx[i] = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
            vy[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
        end
        run("alt", vx, fill(16'h0000), 1'b0, vy, 1'b0);

        // all zero: divide by zero flagged, outputs zero
        run("zero", fill(16'h0000), fill(16'h0000), 1'b0, fill(16'h0000), 1'b1);

        // gamma 0.5
        run("gamma", fill(16'h0100), fill(16'h0080), 1'b1, fill(16'h0080), 1'b0);

        // x0=8, x1=-8: rms 4.0, y=+/-2.0, gamma ~128 saturates both ways
        vx = fill(16'h0000);
        vx[0] = 16'h0800;
        vx[1] = 16'hF800;
        vy = fill(16'h0000);
        vy[0] = 16'h7FFF;
        vy[1] = 16'h8000;
        run("gsat", vx, fill(16'h7FFF), 1'b1, vy, 1'b0);

        // rms = 1 lsb: reciprocal clamps to 0x7FFF
        run("rclamp", fill(16'h0001), fill(16'h0000), 1'b0, fill(16'h007F), 1'b0);

        // enable stall in SQRT plus start while busy
        start_op(fill(16'h0100), fill(16'h0000), 1'b0);
        c1 = 0;
        repeat (10) begin step(); c1++; end
        enable = 1'b0;
        start  = 1'b1;
        repeat (5) begin step(); c1++; end
        chk("stall_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        step();
        c1++;
        start = 1'b0;
        wait_done(c2);
        chk("stall_lat", 32'(c1 + c2), 32'd47);
        chk_y("stall", fill(16'h0100));
        enable = 1'b0;
        step();
        step();
        chk("stall_done_held", 32'(done), 32'd1);
        enable = 1'b1;
        step();
        chk("stall_done_clr", 32'(done), 32'd0);
        seen = 0;
        repeat (50) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("stall_single_done", 32'(seen), 32'd0);

        // tiny x0 only: mean square truncates to 0 -> dbz with nonzero y0
        vx = fill(16'h0000);
        vx[0] = 16'h0001;
        vy = fill(16'h0000);
        vy[0] = 16'h007F;
        run("msz", vx, fill(16'h0000), 1'b0, vy, 1'b1);

        // reset during RECIP aborts without done
        start_op(fill(16'h0100), fill(16'h0000), 1'b0);
        repeat (25) step();
        rst_n = 1'b0;
        #2;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_dbz", 32'(dbz), 32'd0);
        chk_y("abort", fill(16'h0000));
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (45) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        for (int i = 0; i < AW; i++) begin
            vx[i] = (i % 2 == 0) ? 16'h0200 : 16'hFE00;
            vy[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
        end
        run("post_rst", vx, fill(16'h0000), 1'b0, vy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rms_norm_par.md
RMS_NORM_PAR -- requirements
Module: rms_norm_par

Interface
REQ-001 Parameter ARR_WIDTH, default 8: vector length; SHALL be a power of two, at least 2.
REQ-002 Parameter FXP_N, default 16: signed fixed-point word width.
REQ-003 Parameter FXP_Q, default 8: fractional bits; SHALL satisfy FXP_Q < FXP_N.
REQ-004 Parameter LANES, default 2: elements processed per cycle; SHALL divide ARR_WIDTH.
REQ-005 Parameter EPS, default 0: epsilon added to the mean square; unsigned, 2*FXP_Q fractional bits.
REQ-006 Port clk, input, 1: single clock, rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port enable, input, 1: clock-enable; low freezes all state.
REQ-009 Port start, input, 1: request pulse; accepted only in IDLE with enable high.
REQ-010 Port input_arr, input, signed [ARR_WIDTH-1:0][FXP_N-1:0]: vector x.
REQ-011 Port gamma_arr, input, signed [ARR_WIDTH-1:0][FXP_N-1:0]: per-element gain.
REQ-012 Port gamma_en, input, 1: apply gamma_arr when high.
REQ-013 Port output_arr, output, signed [ARR_WIDTH-1:0][FXP_N-1:0]: normalised vector y.
REQ-014 Port busy, output, 1: high whenever the state is not IDLE.
REQ-015 Port done, output, 1: one-cycle completion pulse.
REQ-016 Port dbz, output, 1: the rms was zero; valid with done.

Function
REQ-017 On start acceptance, input_arr, gamma_arr and gamma_en SHALL be captured; later changes to them have no effect on the operation.
REQ-018 FSM SHALL run IDLE -> ACCUM -> SQRT -> RECIP -> SCALE -> DONE -> IDLE.
REQ-019 ACCUM: ARR_WIDTH/LANES cycles; each cycle adds x^2 for LANES elements into an unsigned accumulator of 2*FXP_N+log2(ARR_WIDTH) bits.
REQ-020 Mean square SHALL be acc >> log2(ARR_WIDTH), plus EPS, saturated to 2*FXP_N bits.
REQ-021 SQRT: FXP_N cycles, digit-by-digit, one result bit per cycle; result rms is FXP_N bits with FXP_Q fractional bits, floor.
REQ-022 RECIP: 2*FXP_Q+1 cycles, restoring division of 2^(2*FXP_Q) by rms; quotient clamped to 2^(FXP_N-1)-1.
REQ-023 If rms == 0, RECIP SHALL set the quotient to 2^(FXP_N-1)-1 and assert dbz.
REQ-024 SCALE: ARR_WIDTH/LANES cycles, LANES elements per cycle, ascending index order.
REQ-025 SCALE SHALL compute y = sat((x*recip) >>> FXP_Q); if gamma_en, then y = sat((y*gamma) >>> FXP_Q).
REQ-026 Shifts SHALL be arithmetic (round toward -inf); sat clamps to [-2^(FXP_N-1), 2^(FXP_N-1)-1].
REQ-027 DONE state SHALL last one cycle with done=1.
REQ-028 Latency from the start-accept edge to done high SHALL be 2*(ARR_WIDTH/LANES)+FXP_N+2*FXP_Q+2 enabled cycles.
REQ-029 output_arr and dbz SHALL hold their values from done until the next operation's SCALE overwrites them.
REQ-030 start while busy SHALL be ignored, with no queuing.
REQ-031 enable low SHALL hold the FSM, counters and datapath registers; a done already high SHALL stay high until the next enabled cycle.

Reset
REQ-032 While rst_n is low: state=IDLE, busy=0, done=0, dbz=0, output_arr=0, all counters and accumulators 0.
REQ-033 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-034 start SHALL be accepted on the first enabled edge after rst_n deasserts.

Structure
REQ-035 The fixed-point constants (FXP_N, FXP_Q, ARR_WIDTH defaults), the state enum and the saturate/multiply helper functions SHALL live in the shared fxp_pkg.
REQ-036 The square root SHALL be a sub-module fxp_isqrt (start/done handshake, FXP_N cycles).
REQ-037 The divider and the scale datapath SHALL be implemented inline.

Verification (defaults: 8/16/8/2, EPS=0; latency 42)
REQ-038 All x=0x0100, gamma_en=0 -> all y=0x0100, dbz=0, done exactly 42 cycles after start.
REQ-039 x alternating 0x0200/0xFE00 -> rms=0x0200, recip=0x0080, y alternating 0x0100/0xFF00.
REQ-040 All x=0, EPS=0 -> dbz=1, all y=0x0000, done at cycle 42.
REQ-041 All x=0x0100, gamma_en=1, gamma=0x0080 -> all y=0x0080.
REQ-042 enable low for 5 cycles during SQRT -> done at cycle 47; start pulsed while busy ignored (exactly one done).
REQ-043 rst_n pulsed low during RECIP -> busy=0, output_arr=0, no done; a new start then completes normally.
